// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding selects
// and the NOP encoding that the pipeline registers load on flush/bubble.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_LDSTALL  = 3'd1,
    ST_RAWSTALL = 3'd2,
    ST_MEMWAIT  = 3'd3,
    ST_FLUSH    = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // The youngest producer wins: EX/MEM holds the newer value than MEM/WB.
  function automatic fwd_sel_t fwd_pick(input logic hit_ex, input logic hit_mem);
    fwd_sel_t sel;
    if (hit_ex) begin
      sel = FWD_EXMEM;
    end else if (hit_mem) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Per-source dependency compare against the producers in EX and MEM.
// The WB producer is never compared: the register file writes in the first half cycle.
module hazard_cmp #(
  parameter int REG_ADDR_W = 5,
  parameter bit R0_ZERO    = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  use_rs,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wren,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wren,
  output logic                  hit_ex,
  output logic                  hit_mem
);

  logic zero_src_s;

  assign zero_src_s = R0_ZERO && (rs == {REG_ADDR_W{1'b0}});
  assign hit_ex     = use_rs && ex_wren  && (rs == ex_rd)  && !zero_src_s;
  assign hit_mem    = use_rs && mem_wren && (rs == mem_rd) && !zero_src_s;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer and forwarding-select register for the 5-stage pipeline.
// Optional feature macro: PIPE_FWD_EN (operand forwarding; otherwise RAW hazards stall).
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter bit R0_ZERO      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wren,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wren,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  bubble_idex,
  output logic                  freeze_back,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic        hit_ex_a_s, hit_mem_a_s, hit_ex_b_s, hit_mem_b_s;
  logic        hit_ex_s, ld_use_s, mem_wait_s, stall_hit_s;
  ctrl_state_t state_r, state_nxt_s;
  logic [2:0]  flush_cnt_r, flush_cnt_nxt_s;
  logic        branch_pend_r, branch_pend_nxt_s;
  logic        nxt_stall_s, nxt_flush_s, nxt_bubble_s, nxt_freeze_s;
  logic        stall_pc_r, stall_ifid_r, flush_ifid_r, bubble_idex_r, freeze_back_r;

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W), .R0_ZERO(R0_ZERO)) u_cmp_rs1 (
    .rs(id_rs1), .use_rs(id_use_rs1), .ex_rd(ex_rd), .ex_wren(ex_wren),
    .mem_rd(mem_rd), .mem_wren(mem_wren), .hit_ex(hit_ex_a_s), .hit_mem(hit_mem_a_s)
  );

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W), .R0_ZERO(R0_ZERO)) u_cmp_rs2 (
    .rs(id_rs2), .use_rs(id_use_rs2), .ex_rd(ex_rd), .ex_wren(ex_wren),
    .mem_rd(mem_rd), .mem_wren(mem_wren), .hit_ex(hit_ex_b_s), .hit_mem(hit_mem_b_s)
  );

  assign hit_ex_s   = hit_ex_a_s | hit_ex_b_s;
  assign ld_use_s   = hit_ex_s & ex_memread;
  assign mem_wait_s = mem_req & ~mem_ack;

`ifdef PIPE_FWD_EN
  localparam ctrl_state_t HAZ_ST = ST_LDSTALL;
  assign stall_hit_s = ld_use_s;
`else
  localparam ctrl_state_t HAZ_ST = ST_RAWSTALL;
  // Load-use is a subset of hit_ex; every live producer stalls without forwarding.
  assign stall_hit_s = hit_ex_s | ld_use_s | hit_mem_a_s | hit_mem_b_s;
`endif

  // Next-state, flush counter and pending-branch logic; memory wait has top priority.
  always_comb begin
    state_nxt_s       = state_r;
    flush_cnt_nxt_s   = flush_cnt_r;
    branch_pend_nxt_s = branch_pend_r;
    case (state_r)
      ST_RUN, ST_RAWSTALL: begin
        if (mem_wait_s) begin
          state_nxt_s       = ST_MEMWAIT;
          branch_pend_nxt_s = ex_branch_taken;
        end else if (ex_branch_taken) begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = FLUSH_LOAD;
        end else if (stall_hit_s) begin
          state_nxt_s = HAZ_ST;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LDSTALL: begin
        if (mem_wait_s) begin
          state_nxt_s       = ST_MEMWAIT;
          branch_pend_nxt_s = ex_branch_taken;
        end else if (ex_branch_taken) begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = FLUSH_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (mem_ack) begin
          branch_pend_nxt_s = 1'b0;
          if (branch_pend_r || ex_branch_taken) begin
            state_nxt_s     = ST_FLUSH;
            flush_cnt_nxt_s = FLUSH_LOAD;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          branch_pend_nxt_s = branch_pend_r | ex_branch_taken;
        end
      end
      ST_FLUSH: begin
        // A memory wait mid-flush restarts the full flush once the access completes.
        if (mem_wait_s) begin
          state_nxt_s       = ST_MEMWAIT;
          branch_pend_nxt_s = 1'b1;
        end else if (flush_cnt_r == 3'd0) begin
          state_nxt_s = ST_RUN;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r - 3'd1;
        end
      end
      default: begin
        state_nxt_s       = ST_RUN;
        flush_cnt_nxt_s   = 3'd0;
        branch_pend_nxt_s = 1'b0;
      end
    endcase
  end

  // Control decode of the upcoming state, registered alongside it.
  always_comb begin
    nxt_stall_s  = 1'b0;
    nxt_flush_s  = 1'b0;
    nxt_bubble_s = 1'b0;
    nxt_freeze_s = 1'b0;
    case (state_nxt_s)
      ST_MEMWAIT: begin
        nxt_stall_s  = 1'b1;
        nxt_freeze_s = 1'b1;
      end
      ST_FLUSH: begin
        nxt_flush_s  = 1'b1;
        nxt_bubble_s = 1'b1;
      end
      ST_LDSTALL, ST_RAWSTALL: begin
        nxt_stall_s  = 1'b1;
        nxt_bubble_s = 1'b1;
      end
      default: begin
        nxt_stall_s = 1'b0;
      end
    endcase
  end

  // State, counter and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      flush_cnt_r   <= 3'd0;
      branch_pend_r <= 1'b0;
      stall_pc_r    <= 1'b0;
      stall_ifid_r  <= 1'b0;
      flush_ifid_r  <= 1'b0;
      bubble_idex_r <= 1'b0;
      freeze_back_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      flush_cnt_r   <= flush_cnt_nxt_s;
      branch_pend_r <= branch_pend_nxt_s;
      stall_pc_r    <= nxt_stall_s;
      stall_ifid_r  <= nxt_stall_s;
      flush_ifid_r  <= nxt_flush_s;
      bubble_idex_r <= nxt_bubble_s;
      freeze_back_r <= nxt_freeze_s;
    end
  end

  assign stall_pc    = stall_pc_r;
  assign stall_ifid  = stall_ifid_r;
  assign flush_ifid  = flush_ifid_r;
  assign bubble_idex = bubble_idex_r;
  assign freeze_back = freeze_back_r;

`ifdef PIPE_FWD_EN
  fwd_sel_t fwd_a_r, fwd_b_r;

  // Forwarding selects follow the instruction entering ID/EX; frozen back end holds them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else if (nxt_freeze_s) begin
      fwd_a_r <= fwd_a_r;
      fwd_b_r <= fwd_b_r;
    end else if (nxt_bubble_s) begin
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else begin
      fwd_a_r <= fwd_pick(hit_ex_a_s, hit_mem_a_s);
      fwd_b_r <= fwd_pick(hit_ex_b_s, hit_mem_b_s);
    end
  end

  assign fwd_a = fwd_a_r;
  assign fwd_b = fwd_b_r;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl; expectations follow PIPE_FWD_EN.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze_back}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11010;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_FRZ   = 5'b11001;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] exrd;
    logic       exw, exmr;
    logic [4:0] memrd;
    logic       memw, tk, mreq, mack;
    logic [4:0] ectl;
    logic [1:0] ea, eb;
  } vec_t;

  logic       clk, rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_use_rs1, id_use_rs2, ex_wren, ex_memread, mem_wren;
  logic       ex_branch_taken, mem_req, mem_ack;
  logic       stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze_back;
  logic [1:0] fwd_a, fwd_b;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_wren(ex_wren), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_wren(mem_wren), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .freeze_back(freeze_back), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string n, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] exrd,
                     input logic exw, input logic exmr, input logic [4:0] memrd,
                     input logic memw, input logic tk, input logic mreq, input logic mack,
                     input logic [4:0] ectl, input logic [1:0] ea, input logic [1:0] eb);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.exrd = exrd; v.exw = exw; v.exmr = exmr; v.memrd = memrd; v.memw = memw;
    v.tk = tk; v.mreq = mreq; v.mack = mack; v.ectl = ectl; v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2; id_use_rs2 = v.u2;
    ex_rd = v.exrd; ex_wren = v.exw; ex_memread = v.exmr;
    mem_rd = v.memrd; mem_wren = v.memw;
    ex_branch_taken = v.tk; mem_req = v.mreq; mem_ack = v.mack;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_use_rs1 = 1'b0; id_rs2 = 5'd0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_wren = 1'b0; ex_memread = 1'b0; mem_rd = 5'd0; mem_wren = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic chk(input string n, input logic [4:0] ectl, input logic [1:0] ea,
                     input logic [1:0] eb);
    logic [4:0] got;
    got = {stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze_back};
    checks++;
    if (got !== ectl) begin
      failures++;
      $display("FAIL %s ctl: got %b expected %b", n, got, ectl);
    end
    checks++;
    if (fwd_a !== ea || fwd_b !== eb) begin
      failures++;
      $display("FAIL %s fwd: got a=%b b=%b expected a=%b b=%b", n, fwd_a, fwd_b, ea, eb);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   name          rs1  u1  rs2  u2  exrd exw exmr memrd memw tk mreq mack  ctl  fwd_a fwd_b
    add("idle",        5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);
    add("ex_fwd_a",    5'd3,1'b1,5'd7,1'b1,5'd3,1'b1,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,
        FWD ? C_NONE : C_STALL, FWD ? 2'b01 : 2'b00, 2'b00);
    add("mem_fwd_a",   5'd3,1'b1,5'd7,1'b1,5'd0,1'b0,1'b0,5'd3,1'b1,1'b0,1'b0,1'b0,
        FWD ? C_NONE : C_STALL, FWD ? 2'b10 : 2'b00, 2'b00);
    add("wb_clear",    5'd3,1'b1,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);
    add("r0_src",      5'd0,1'b1,5'd0,1'b1,5'd0,1'b1,1'b0,5'd0,1'b1,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);
    add("ex_fwd_b",    5'd1,1'b1,5'd9,1'b1,5'd9,1'b1,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,
        FWD ? C_NONE : C_STALL, 2'b00, FWD ? 2'b01 : 2'b00);
    add("idle2",       5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);
    add("no_use",      5'd6,1'b0,5'd0,1'b0,5'd6,1'b1,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);
    add("no_wren",     5'd6,1'b1,5'd0,1'b0,5'd6,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);
    add("ex_over_mem", 5'd8,1'b1,5'd0,1'b0,5'd8,1'b1,1'b0,5'd8,1'b1,1'b0,1'b0,1'b0,
        FWD ? C_NONE : C_STALL, FWD ? 2'b01 : 2'b00, 2'b00);
    add("idle3",       5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);
    add("load_use",    5'd5,1'b1,5'd0,1'b0,5'd5,1'b1,1'b1,5'd0,1'b0,1'b0,1'b0,1'b0, C_STALL, 2'b00, 2'b00);
    add("load_mem",    5'd5,1'b1,5'd0,1'b0,5'd0,1'b0,1'b0,5'd5,1'b1,1'b0,1'b0,1'b0,
        FWD ? C_NONE : C_STALL, FWD ? 2'b10 : 2'b00, 2'b00);
    add("idle4",       5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);
    add("tk_ld_use",   5'd5,1'b1,5'd0,1'b0,5'd5,1'b1,1'b1,5'd0,1'b0,1'b1,1'b0,1'b0, C_FLUSH, 2'b00, 2'b00);
    add("flush2",      5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_FLUSH, 2'b00, 2'b00);
    add("flush_end",   5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);
    add("pre_wait",    5'd3,1'b1,5'd0,1'b0,5'd3,1'b1,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,
        FWD ? C_NONE : C_STALL, FWD ? 2'b01 : 2'b00, 2'b00);
    add("wait1",       5'd3,1'b1,5'd0,1'b0,5'd3,1'b1,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,
        C_FRZ, FWD ? 2'b01 : 2'b00, 2'b00);
    add("wait2_tk",    5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b1,1'b0,
        C_FRZ, FWD ? 2'b01 : 2'b00, 2'b00);
    add("wait3",       5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,
        C_FRZ, FWD ? 2'b01 : 2'b00, 2'b00);
    add("ack_flush",   5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b1, C_FLUSH, 2'b00, 2'b00);
    add("flush_b",     5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_FLUSH, 2'b00, 2'b00);
    add("run_b",       5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);
    add("zero_wait",   5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b1, C_NONE, 2'b00, 2'b00);
    add("wait_nopend", 5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0, C_FRZ, 2'b00, 2'b00);
    add("ack_run",     5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b1, C_NONE, 2'b00, 2'b00);
    add("idle5",       5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE, 2'b00, 2'b00);

    rst_n = 1'b0;
    idle();
    #12;
    chk("reset", C_NONE, 2'b00, 2'b00);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      step();
      chk(vecs[i].name, vecs[i].ectl, vecs[i].ea, vecs[i].eb);
    end

    // Reset pulled mid-flush: outputs clear without a clock edge.
    idle();
    ex_branch_taken = 1'b1;
    step();
    chk("rst_pre_flush", C_FLUSH, 2'b00, 2'b00);
    ex_branch_taken = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", C_NONE, 2'b00, 2'b00);
    step();
    chk("rst_held", C_NONE, 2'b00, 2'b00);
    #2;
    rst_n = 1'b1;
    step();
    chk("rst_run", C_NONE, 2'b00, 2'b00);
    ex_branch_taken = 1'b1;
    step();
    chk("post_rst_flush1", C_FLUSH, 2'b00, 2'b00);
    ex_branch_taken = 1'b0;
    step();
    chk("post_rst_flush2", C_FLUSH, 2'b00, 2'b00);
    step();
    chk("post_rst_run", C_NONE, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
